pipe_stage_ctrl: RTL and testbench

- Owns the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers for the instruction-identity and control fields of the 5-stage RV32I core.
- Consumes the hazard unit's StallF/StallD/FlushD/FlushE.
- Produces the register indices, RegWrite and ResultSrc signals per stage that the hazard unit evaluates.
- Keeps per-stage valid bits and retire/stall/flush performance counters.

---
 rtl/riscv_pkg.sv | 30 +++
 rtl/perf_counter.sv | 22 ++
 rtl/pipe_stage_ctrl.sv | 141 ++++++++++++++
 tb/tb_pipe_stage_ctrl.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I definitions for the pipeline control slice: the canonical NOP,
// ResultSrc encodings and the register-index field positions of an instruction.
package riscv_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h00000013;  // addi x0,x0,0

    typedef enum logic [1:0] {
        RES_ALU  = 2'b00,
        RES_LOAD = 2'b01,
        RES_PC4  = 2'b10
    } resultSrc_t;

    localparam int REG_IDX_W = 5;
    localparam int RD_LSB    = 7;
    localparam int RS1_LSB   = 15;
    localparam int RS2_LSB   = 20;

    function automatic logic [REG_IDX_W-1:0] rdField(input logic [31:0] instr);
        return instr[RD_LSB +: REG_IDX_W];
    endfunction

    function automatic logic [REG_IDX_W-1:0] rs1Field(input logic [31:0] instr);
        return instr[RS1_LSB +: REG_IDX_W];
    endfunction

    function automatic logic [REG_IDX_W-1:0] rs2Field(input logic [31:0] instr);
        return instr[RS2_LSB +: REG_IDX_W];
    endfunction

endpackage

// File: rtl/perf_counter.sv
// Free-running event counter: adds one per qualifying cycle, wraps modulo
// 2^CNT_W, and is cleared (never incremented) in a reset cycle.
module perf_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values and simulation order cannot change the result.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (inc) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pipe_stage_ctrl.sv
// Instruction-identity and control pipeline registers (IF/ID, ID/EX, EX/MEM,
// MEM/WB) of the 5-stage RV32I core, with per-stage valid bits and perf counters.
module pipe_stage_ctrl
    import riscv_pkg::RES_ALU;
    import riscv_pkg::rdField;
    import riscv_pkg::rs1Field;
    import riscv_pkg::rs2Field;
#(
    parameter int          XLEN      = 32,
    parameter int          CNT_W     = 32,
    parameter logic [31:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      InstrF,
    input  logic [XLEN-1:0]  PCF,
    input  logic [XLEN-1:0]  PCPlus4F,
    input  logic             RegWriteD,
    input  logic [1:0]       ResultSrcD,
    input  logic             MemWriteD,
    input  logic             StallF,
    input  logic             StallD,
    input  logic             FlushD,
    input  logic             FlushE,
    output logic [31:0]      InstrD,
    output logic [XLEN-1:0]  PCD,
    output logic [XLEN-1:0]  PCPlus4D,
    output logic [4:0]       Rs1D,
    output logic [4:0]       Rs2D,
    output logic [4:0]       RdD,
    output logic [4:0]       Rs1E,
    output logic [4:0]       Rs2E,
    output logic [4:0]       RdE,
    output logic             RegWriteE,
    output logic [1:0]       ResultSrcE,
    output logic             MemWriteE,
    output logic [XLEN-1:0]  PCE,
    output logic [4:0]       RdM,
    output logic             RegWriteM,
    output logic [1:0]       ResultSrcM,
    output logic             MemWriteM,
    output logic [4:0]       RdW,
    output logic             RegWriteW,
    output logic [1:0]       ResultSrcW,
    output logic             ValidD,
    output logic             ValidE,
    output logic             ValidM,
    output logic             ValidW,
    output logic [CNT_W-1:0] InstRetired,
    output logic [CNT_W-1:0] LoadUseStalls,
    output logic [CNT_W-1:0] Flushes
);

    assign Rs1D = rs1Field(InstrD);
    assign Rs2D = rs2Field(InstrD);
    assign RdD  = rdField(InstrD);

    // IF/ID: a flush wins over a stall.
    always_ff @(posedge clk) begin
        if (rst || FlushD) begin
            InstrD   <= NOP_INSTR;
            PCD      <= '0;
            PCPlus4D <= '0;
            ValidD   <= 1'b0;
        end else if (!StallD) begin
            InstrD   <= InstrF;
            PCD      <= PCF;
            PCPlus4D <= PCPlus4F;
            ValidD   <= 1'b1;
        end
    end

    // ID/EX: decode controls are qualified by ValidD so a dead D stage can
    // never write the register file or memory.
    always_ff @(posedge clk) begin
        if (rst || FlushE) begin
            Rs1E       <= '0;
            Rs2E       <= '0;
            RdE        <= '0;
            RegWriteE  <= 1'b0;
            ResultSrcE <= RES_ALU;
            MemWriteE  <= 1'b0;
            PCE        <= '0;
            ValidE     <= 1'b0;
        end else begin
            Rs1E       <= Rs1D;
            Rs2E       <= Rs2D;
            RdE        <= RdD;
            RegWriteE  <= RegWriteD & ValidD;
            ResultSrcE <= ValidD ? ResultSrcD : RES_ALU;
            MemWriteE  <= MemWriteD & ValidD;
            PCE        <= PCD;
            ValidE     <= ValidD;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            RdM        <= '0;
            RegWriteM  <= 1'b0;
            ResultSrcM <= RES_ALU;
            MemWriteM  <= 1'b0;
            ValidM     <= 1'b0;
            RdW        <= '0;
            RegWriteW  <= 1'b0;
            ResultSrcW <= RES_ALU;
            ValidW     <= 1'b0;
        end else begin
            RdM        <= RdE;
            RegWriteM  <= RegWriteE;
            ResultSrcM <= ResultSrcE;
            MemWriteM  <= MemWriteE;
            ValidM     <= ValidE;
            RdW        <= RdM;
            RegWriteW  <= RegWriteM;
            ResultSrcW <= ResultSrcM;
            ValidW     <= ValidM;
        end
    end

    // A stall overridden by FlushD is really a redirect, so it counts as a flush.
    logic loadUseStall;
    logic redirect;
    assign loadUseStall = StallD & ~FlushD;
    assign redirect     = FlushE & ~loadUseStall;

    perf_counter #(.CNT_W(CNT_W)) uRetired (
        .clk(clk), .rst(rst), .inc(ValidW), .count(InstRetired)
    );

    perf_counter #(.CNT_W(CNT_W)) uLoadUse (
        .clk(clk), .rst(rst), .inc(loadUseStall), .count(LoadUseStalls)
    );

    perf_counter #(.CNT_W(CNT_W)) uFlushes (
        .clk(clk), .rst(rst), .inc(redirect), .count(Flushes)
    );

    stallConsistent: assert property (@(posedge clk) disable iff (rst) StallF == StallD);

endmodule

// File: tb/tb_pipe_stage_ctrl.sv
// Directed bench for pipe_stage_ctrl: a vector table for straight-line flow and
// hand-written sequences for stall, redirect, flush-vs-stall, wrap and reset.
module tb_pipe_stage_ctrl;

    localparam int XLEN  = 32;
    localparam int CNT_W = 4;

    localparam logic [31:0] NOP   = 32'h00000013;
    localparam logic [31:0] ADDI1 = 32'h00500093;  // addi x1,x0,5
    localparam logic [31:0] ADD2  = 32'h00108133;  // add  x2,x1,x1
    localparam logic [31:0] LW3   = 32'h00002183;  // lw   x3,0(x0)
    localparam logic [31:0] ADD4  = 32'h00318233;  // add  x4,x3,x3

    logic             clk = 1'b0;
    logic             rst;
    logic [31:0]      InstrF;
    logic [XLEN-1:0]  PCF, PCPlus4F;
    logic             RegWriteD, MemWriteD;
    logic [1:0]       ResultSrcD;
    logic             StallF, StallD, FlushD, FlushE;
    logic [31:0]      InstrD;
    logic [XLEN-1:0]  PCD, PCPlus4D, PCE;
    logic [4:0]       Rs1D, Rs2D, RdD, Rs1E, Rs2E, RdE, RdM, RdW;
    logic             RegWriteE, MemWriteE, RegWriteM, MemWriteM, RegWriteW;
    logic [1:0]       ResultSrcE, ResultSrcM, ResultSrcW;
    logic             ValidD, ValidE, ValidM, ValidW;
    logic [CNT_W-1:0] InstRetired, LoadUseStalls, Flushes;

    int checkCount = 0;
    int passCount  = 0;

    pipe_stage_ctrl #(.XLEN(XLEN), .CNT_W(CNT_W), .NOP_INSTR(NOP)) dut (
        .clk(clk), .rst(rst), .InstrF(InstrF), .PCF(PCF), .PCPlus4F(PCPlus4F),
        .RegWriteD(RegWriteD), .ResultSrcD(ResultSrcD), .MemWriteD(MemWriteD),
        .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
        .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
        .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
        .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE), .MemWriteE(MemWriteE), .PCE(PCE),
        .RdM(RdM), .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM), .MemWriteM(MemWriteM),
        .RdW(RdW), .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW),
        .ValidD(ValidD), .ValidE(ValidE), .ValidM(ValidM), .ValidW(ValidW),
        .InstRetired(InstRetired), .LoadUseStalls(LoadUseStalls), .Flushes(Flushes)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instrF;
        logic [31:0] pcF;
        logic        regWriteD;
        logic        memWriteD;
        logic        flushD;
        logic [31:0] expInstrD;
        logic [31:0] expPcD;
        logic        expValidD;
        logic [4:0]  expRdE;
        logic        expRegWriteE;
        logic        expMemWriteE;
        logic        expValidE;
        logic [31:0] expPcE;
        logic [4:0]  expRdM;
        logic        expRegWriteM;
        logic [4:0]  expRdW;
        logic        expRegWriteW;
        logic        expValidW;
        logic [3:0]  expRetired;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] instr, input logic [31:0] pc, input logic rw,
                         input logic [1:0] rs, input logic mw, input logic stall,
                         input logic fD, input logic fE);
        InstrF     = instr;
        PCF        = pc;
        PCPlus4F   = pc + 32'd4;
        RegWriteD  = rw;
        ResultSrcD = rs;
        MemWriteD  = mw;
        StallF     = stall;
        StallD     = stall;
        FlushD     = fD;
        FlushE     = fE;
    endtask

    task automatic doReset();
        rst = 1'b1;
        drive(NOP, 32'h0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        // Straight-line flow, then bubbles fed through FlushD to drain.
        vecs[0] = '{ADDI1, 32'h100, 1'b0, 1'b0, 1'b0,
                    ADDI1, 32'h100, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0,   5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 4'd0};
        vecs[1] = '{ADD2,  32'h104, 1'b1, 1'b0, 1'b0,
                    ADD2,  32'h104, 1'b1, 5'd1, 1'b1, 1'b0, 1'b1, 32'h100, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 4'd0};
        vecs[2] = '{ADD4,  32'h108, 1'b1, 1'b0, 1'b1,
                    NOP,   32'h0,   1'b0, 5'd2, 1'b1, 1'b0, 1'b1, 32'h104, 5'd1, 1'b1, 5'd0, 1'b0, 1'b0, 4'd0};
        vecs[3] = '{NOP,   32'h10C, 1'b1, 1'b1, 1'b1,
                    NOP,   32'h0,   1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0,   5'd2, 1'b1, 5'd1, 1'b1, 1'b1, 4'd0};
        vecs[4] = '{NOP,   32'h110, 1'b1, 1'b1, 1'b1,
                    NOP,   32'h0,   1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0,   5'd0, 1'b0, 5'd2, 1'b1, 1'b1, 4'd1};
        vecs[5] = '{NOP,   32'h114, 1'b1, 1'b1, 1'b1,
                    NOP,   32'h0,   1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0,   5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 4'd2};
        vecs[6] = '{NOP,   32'h118, 1'b1, 1'b1, 1'b1,
                    NOP,   32'h0,   1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0,   5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 4'd2};

        // Reset held two cycles with a live instruction on the fetch bus.
        rst = 1'b1;
        drive(ADDI1, 32'h80, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        step();
        check("rst InstrD", InstrD, NOP);
        check("rst PCD", PCD, 32'h0);
        check("rst ValidD", ValidD, 1'b0);
        check("rst ValidE", ValidE, 1'b0);
        check("rst ValidM", ValidM, 1'b0);
        check("rst ValidW", ValidW, 1'b0);
        check("rst RegWriteE", RegWriteE, 1'b0);
        check("rst InstRetired", InstRetired, 4'd0);
        check("rst LoadUseStalls", LoadUseStalls, 4'd0);
        check("rst Flushes", Flushes, 4'd0);
        rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            drive(vecs[i].instrF, vecs[i].pcF, vecs[i].regWriteD, 2'b00, vecs[i].memWriteD,
                  1'b0, vecs[i].flushD, 1'b0);
            step();
            check($sformatf("v%0d InstrD", i), InstrD, vecs[i].expInstrD);
            check($sformatf("v%0d PCD", i), PCD, vecs[i].expPcD);
            check($sformatf("v%0d ValidD", i), ValidD, vecs[i].expValidD);
            check($sformatf("v%0d RdE", i), RdE, vecs[i].expRdE);
            check($sformatf("v%0d RegWriteE", i), RegWriteE, vecs[i].expRegWriteE);
            check($sformatf("v%0d MemWriteE", i), MemWriteE, vecs[i].expMemWriteE);
            check($sformatf("v%0d ValidE", i), ValidE, vecs[i].expValidE);
            check($sformatf("v%0d PCE", i), PCE, vecs[i].expPcE);
            check($sformatf("v%0d RdM", i), RdM, vecs[i].expRdM);
            check($sformatf("v%0d RegWriteM", i), RegWriteM, vecs[i].expRegWriteM);
            check($sformatf("v%0d RdW", i), RdW, vecs[i].expRdW);
            check($sformatf("v%0d RegWriteW", i), RegWriteW, vecs[i].expRegWriteW);
            check($sformatf("v%0d ValidW", i), ValidW, vecs[i].expValidW);
            check($sformatf("v%0d InstRetired", i), InstRetired, vecs[i].expRetired);
        end

        // Load-use: lw x3 followed by a dependent add; one stall cycle.
        doReset();
        drive(LW3, 32'h200, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        check("lu InstrD lw", InstrD, LW3);
        check("lu Rs1D", Rs1D, 5'd0);
        drive(ADD4, 32'h204, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        check("lu RdE lw", RdE, 5'd3);
        check("lu ResultSrcE", ResultSrcE, 2'b01);
        check("lu Rs1D add", Rs1D, 5'd3);
        check("lu Rs2D add", Rs2D, 5'd3);
        drive(NOP, 32'h208, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1);
        step();
        check("lu InstrD held", InstrD, ADD4);
        check("lu PCD held", PCD, 32'h204);
        check("lu PCPlus4D held", PCPlus4D, 32'h208);
        check("lu ValidE bubble", ValidE, 1'b0);
        check("lu RegWriteE bubble", RegWriteE, 1'b0);
        check("lu RdE bubble", RdE, 5'd0);
        check("lu RdM", RdM, 5'd3);
        check("lu ResultSrcM", ResultSrcM, 2'b01);
        check("lu LoadUseStalls", LoadUseStalls, 4'd1);
        check("lu Flushes", Flushes, 4'd0);
        drive(NOP, 32'h208, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        check("lu InstrD next", InstrD, NOP);
        check("lu RdE add", RdE, 5'd4);
        check("lu Rs1E add", Rs1E, 5'd3);
        check("lu Rs2E add", Rs2E, 5'd3);
        check("lu RegWriteE add", RegWriteE, 1'b1);
        check("lu ValidE add", ValidE, 1'b1);
        check("lu RegWriteM bubble", RegWriteM, 1'b0);
        check("lu RdW lw", RdW, 5'd3);
        check("lu ResultSrcW", ResultSrcW, 2'b01);
        check("lu LoadUseStalls hold", LoadUseStalls, 4'd1);

        // Taken branch: flush D and E, then drain with bubbles.
        doReset();
        drive(ADDI1, 32'h300, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        drive(ADD2, 32'h304, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        check("br RdE", RdE, 5'd1);
        drive(ADD4, 32'h308, 1'b1, 2'b00, 1'b1, 1'b0, 1'b1, 1'b1);
        step();
        check("br InstrD", InstrD, NOP);
        check("br ValidD", ValidD, 1'b0);
        check("br ValidE", ValidE, 1'b0);
        check("br RdE", RdE, 5'd0);
        check("br MemWriteE", MemWriteE, 1'b0);
        check("br PCE", PCE, 32'h0);
        check("br RdM", RdM, 5'd1);
        check("br Flushes", Flushes, 4'd1);
        check("br LoadUseStalls", LoadUseStalls, 4'd0);
        for (int i = 0; i < 4; i++) begin
            drive(NOP, 32'h0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
            step();
        end
        check("br InstRetired", InstRetired, 4'd1);
        check("br Flushes hold", Flushes, 4'd1);
        check("br ValidW drained", ValidW, 1'b0);

        // Stall and flush together: flush wins, counted as a redirect.
        doReset();
        drive(ADDI1, 32'h400, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        drive(ADD2, 32'h404, 1'b1, 2'b00, 1'b0, 1'b1, 1'b1, 1'b1);
        step();
        check("sf InstrD", InstrD, NOP);
        check("sf ValidD", ValidD, 1'b0);
        check("sf PCD", PCD, 32'h0);
        check("sf ValidE", ValidE, 1'b0);
        check("sf LoadUseStalls", LoadUseStalls, 4'd0);
        check("sf Flushes", Flushes, 4'd1);

        // Counter wrap with back-to-back retirement.
        doReset();
        for (int i = 0; i < 4; i++) begin
            drive(ADDI1, 32'h500 + 32'(4 * i), 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
            step();
        end
        check("wr ValidW first", ValidW, 1'b1);
        check("wr InstRetired 0", InstRetired, 4'd0);
        for (int i = 0; i < 15; i++) step();
        check("wr InstRetired F", InstRetired, 4'hF);
        step();
        check("wr InstRetired wrap", InstRetired, 4'h0);
        step();
        check("wr InstRetired 1", InstRetired, 4'h1);
        drive(ADDI1, 32'h600, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1);
        step();
        drive(ADDI1, 32'h604, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
        step();
        check("wr LoadUseStalls pre", LoadUseStalls, 4'd1);
        check("wr Flushes pre", Flushes, 4'd1);

        // Reset mid-stream with stall/flush/valid activity still present.
        rst = 1'b1;
        drive(ADDI1, 32'h608, 1'b1, 2'b00, 1'b1, 1'b1, 1'b0, 1'b1);
        step();
        check("mr InstRetired", InstRetired, 4'd0);
        check("mr LoadUseStalls", LoadUseStalls, 4'd0);
        check("mr Flushes", Flushes, 4'd0);
        check("mr ValidD", ValidD, 1'b0);
        check("mr ValidE", ValidE, 1'b0);
        check("mr ValidM", ValidM, 1'b0);
        check("mr ValidW", ValidW, 1'b0);
        check("mr InstrD", InstrD, NOP);
        check("mr RegWriteW", RegWriteW, 1'b0);
        check("mr MemWriteM", MemWriteM, 1'b0);
        step();
        check("mr LoadUseStalls held", LoadUseStalls, 4'd0);
        rst = 1'b0;
        drive(NOP, 32'h0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        step();

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
